// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port memory arbiter with starvation guard and WAIT timeout
module mem_arbiter #(
  parameter int MAX_CONSEC = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p0_we,
  output logic        p0_ack,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic        p1_we,
  output logic        p1_ack,
  output logic [31:0] p1_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done,
  output logic        owner,
  output logic        timeout_err
);

  localparam int CW = $clog2(MAX_CONSEC + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CMAX  = CW'(MAX_CONSEC);
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state;
  logic [CW-1:0]  consec_cnt;
  logic [WW-1:0]  wait_cnt;
  logic           p1_wins;
  logic           finish;
  logic [31:0]    resp_data;

  // Port 1 only wins on its own, or once port 0 has used up its consecutive budget.
  assign p1_wins   = p1_req && (!p0_req || consec_cnt == CMAX);
  assign finish    = mem_done || (wait_cnt == WLAST);
  assign resp_data = mem_done ? mem_rdata : 32'hFFFF_FFFF;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      consec_cnt  <= '0;
      wait_cnt    <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      p0_ack      <= 1'b0;
      p1_ack      <= 1'b0;
      p0_rdata    <= '0;
      p1_rdata    <= '0;
      owner       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (p0_req || p1_req) begin
            owner     <= p1_wins;
            mem_addr  <= p1_wins ? p1_addr  : p0_addr;
            mem_wdata <= p1_wins ? p1_wdata : p0_wdata;
            mem_we    <= p1_wins ? p1_we    : p0_we;
            mem_req   <= 1'b1;
            state     <= ISSUE;
            if (p1_wins || !p1_req)
              consec_cnt <= '0;
            else if (consec_cnt != CMAX)
              consec_cnt <= consec_cnt + CW'(1);
          end
        end
        ISSUE: begin
          mem_req  <= 1'b0;
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (!mem_done)
            wait_cnt <= wait_cnt + WW'(1);
          if (finish) begin
            if (owner) begin
              p1_rdata <= resp_data;
              p1_ack   <= 1'b1;
            end else begin
              p0_rdata <= resp_data;
              p0_ack   <= 1'b1;
            end
            if (!mem_done)
              timeout_err <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          p0_ack <= 1'b0;
          p1_ack <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  localparam int MAXC = 4;
  localparam int TMO  = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p0_ack, p1_req, p1_we, p1_ack;
  logic [31:0] p0_addr, p0_wdata, p0_rdata, p1_addr, p1_wdata, p1_rdata;
  logic        mem_req, mem_we, mem_done, owner, timeout_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int          checks = 0;
  int          errors = 0;
  int          exp_port_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] last_rd[2];

  mem_arbiter #(.MAX_CONSEC(MAXC), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_we(p0_we),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_we(p1_we),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .owner(owner), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_req(int port, logic v, logic [31:0] a, logic [31:0] w, logic we);
    if (port == 0) begin
      p0_req = v; p0_addr = a; p0_wdata = w; p0_we = we;
    end else begin
      p1_req = v; p1_addr = a; p1_wdata = w; p1_we = we;
    end
  endtask

  task automatic wait_issue(output bit ok);
    int n;
    n = 99;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mem_req === 1'b1) begin
        n = i;
        break;
      end
    end
    chk("issue_latency", n, 0);
    ok = (n < 20);
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_mem"}, {mem_req, mem_we, owner, timeout_err, p0_ack, p1_ack}, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_p0_rdata"}, p0_rdata, 0);
    chk({tag, "_p1_rdata"}, p1_rdata, 0);
  endtask

  task automatic run_txn(int port, logic [31:0] a, logic [31:0] w, logic we, int dly,
                         logic [31:0] rd, bit stray, bit drop);
    int ep;
    logic [31:0] ed;
    bit ok;
    exp_port_q.push_back(port);
    exp_data_q.push_back(rd);
    set_req(port, 1'b1, a, w, we);
    wait_issue(ok);
    if (ok) begin
      chk("issue_addr", mem_addr, a);
      chk("issue_wdata", mem_wdata, w);
      chk("issue_we", mem_we, we);
      chk("issue_owner", owner, port);
    end
    if (drop) set_req(port, 1'b0, a, w, we);
    if (stray) begin
      mem_done = 1'b1;
      mem_rdata = 32'hBAD0_BAD0;
    end
    step();
    mem_done = 1'b0;
    chk("wait_mem_req_low", mem_req, 0);
    for (int i = 0; i < dly; i++) begin
      chk("wait_addr_stable", mem_addr, a);
      chk("wait_no_ack", {p0_ack, p1_ack}, 0);
      step();
    end
    mem_done = 1'b1;
    mem_rdata = rd;
    step();
    mem_done = 1'b0;
    mem_rdata = $urandom();
    ep = exp_port_q.pop_front();
    ed = exp_data_q.pop_front();
    chk("resp_ack", (ep == 0) ? p0_ack : p1_ack, 1);
    chk("resp_other_ack", (ep == 0) ? p1_ack : p0_ack, 0);
    chk("resp_rdata", (ep == 0) ? p0_rdata : p1_rdata, ed);
    chk("resp_other_rdata", (ep == 0) ? p1_rdata : p0_rdata, last_rd[1-ep]);
    chk("resp_wdata_stable", mem_wdata, w);
    chk("resp_we_stable", mem_we, we);
    set_req(port, 1'b0, a, w, we);
    step();
    chk("ack_one_cycle", {p0_ack, p1_ack}, 0);
    last_rd[ep] = ed;
  endtask

  initial begin
    bit ok;
    int n;
    rst = 1'b0;
    p0_req = 0; p0_addr = 0; p0_wdata = 0; p0_we = 0;
    p1_req = 0; p1_addr = 0; p1_wdata = 0; p1_we = 0;
    mem_done = 0; mem_rdata = 0;
    last_rd[0] = 0; last_rd[1] = 0;
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b1;
    step();

    // Single read with mem_done one cycle after WAIT entry
    run_txn(0, 32'h100, 32'h0, 1'b0, 1, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // Both ports requesting continuously: p0 x4 then p1, twice
    p0_req = 1; p0_addr = 32'hA0; p0_wdata = 0; p0_we = 0;
    p1_req = 1; p1_addr = 32'hB0; p1_wdata = 0; p1_we = 0;
    for (int k = 0; k < 10; k++) begin
      exp_port_q.push_back((k % 5 == 4) ? 1 : 0);
      exp_data_q.push_back(32'h5000 + k);
    end
    for (int k = 0; k < 10; k++) begin
      int ep;
      logic [31:0] ed;
      ep = exp_port_q.pop_front();
      ed = exp_data_q.pop_front();
      wait_issue(ok);
      chk("arb_owner", owner, ep);
      chk("arb_addr", mem_addr, (ep == 0) ? 32'hA0 : 32'hB0);
      step();
      mem_done = 1'b1;
      mem_rdata = ed;
      step();
      mem_done = 1'b0;
      chk("arb_ack", (ep == 0) ? {p0_ack, p1_ack} : {p1_ack, p0_ack}, 2'b10);
      chk("arb_rdata", (ep == 0) ? p0_rdata : p1_rdata, ed);
      last_rd[ep] = ed;
      step();
    end
    p0_req = 0; p1_req = 0;
    step();

    // Stray mem_done while idle
    mem_done = 1'b1; mem_rdata = 32'h7777_7777;
    step();
    mem_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_stray_ack", {p0_ack, p1_ack, mem_req}, 0);
      chk("idle_stray_p0_rdata", p0_rdata, last_rd[0]);
      chk("idle_stray_p1_rdata", p1_rdata, last_rd[1]);
    end

    // Write from p1, 3 WAIT cycles; then stray done in ISSUE; then dropped request
    run_txn(1, 32'h2000, 32'h1234_5678, 1'b1, 3, 32'h0BAD_F00D, 1'b0, 1'b0);
    run_txn(0, 32'h3000, 32'h0, 1'b0, 2, 32'hCAFE_0001, 1'b1, 1'b0);
    run_txn(1, 32'h4000, 32'hAAAA_5555, 1'b0, 0, 32'hCAFE_0002, 1'b0, 1'b1);

    // Timeout: mem_done never arrives
    chk("timeout_err_clear", timeout_err, 0);
    set_req(0, 1'b1, 32'h500, 32'h0, 1'b0);
    wait_issue(ok);
    n = 9999;
    for (int i = 1; i <= 400; i++) begin
      step();
      if (p0_ack === 1'b1) begin
        n = i;
        break;
      end
    end
    chk("timeout_latency", n, TMO + 1);
    chk("timeout_err_set", timeout_err, 1);
    chk("timeout_rdata", p0_rdata, 32'hFFFF_FFFF);
    chk("timeout_p1_ack", p1_ack, 0);
    last_rd[0] = 32'hFFFF_FFFF;
    p0_req = 0;
    step();
    run_txn(0, 32'h600, 32'h0, 1'b0, 0, 32'h1111_2222, 1'b0, 1'b0);
    chk("timeout_err_sticky", timeout_err, 1);

    // Reset during WAIT, then a spurious mem_done after release
    set_req(1, 1'b1, 32'h700, 32'h0, 1'b0);
    wait_issue(ok);
    step();
    #1 rst = 1'b0;
    #1 check_all_zero("async_reset");
    step();
    check_all_zero("held_reset");
    rst = 1'b1;
    p1_req = 0;
    last_rd[0] = 0; last_rd[1] = 0;
    step();
    mem_done = 1'b1; mem_rdata = 32'h9999_9999;
    step();
    mem_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all_zero("post_reset_stray");
    end
    run_txn(1, 32'h800, 32'h0, 1'b0, 1, 32'h8888_0000, 1'b0, 1'b0);

    chk("scoreboard_empty", exp_port_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
